// File: rtl/booth_mult.sv
// Radix-2 Booth signed multiplier with a three-state IDLE/RUN/DONE sequencer.
// Optional zero-operand shortcut enabled by defining BOOTH_MULT_ZERO_SHORTCUT_EN.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; hi/lo hold the last result
    // RUN   | one Booth recode + arithmetic shift per clock
    // DONE  | result valid, done pulse; start is ignored here
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH:0]   mult;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   accNext;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qNext;
    logic             qm1;
    logic [CW-1:0]    count;
    logic             zeroOperand;

`ifdef BOOTH_MULT_ZERO_SHORTCUT_EN
    assign zeroOperand = (a == '0) || (b == '0);
`else
    assign zeroOperand = 1'b0;
`endif

    // The extra accumulator bit keeps acc - M exact when M is the most negative value.
    always_comb begin
        sum = acc;
        case ({q[0], qm1})
            2'b01:   sum = acc + mult;
            2'b10:   sum = acc - mult;
            default: sum = acc;
        endcase
        accNext = {sum[WIDTH], sum[WIDTH:1]};
        qNext   = {sum[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mult  <= '0;
            acc   <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (zeroOperand) begin
                            hi    <= '0;
                            lo    <= '0;
                            state <= DONE;
                        end else begin
                            mult  <= {a[WIDTH-1], a};
                            acc   <= '0;
                            q     <= b;
                            qm1   <= 1'b0;
                            count <= CW'(WIDTH);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    q     <= qNext;
                    qm1   <= q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        hi    <= accNext[WIDTH-1:0];
                        lo    <= qNext;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
